// File: rtl/sd_xfer_sequencer.sv
// Sequences one single/multi-block SD data transfer between the ADMA engine and the DAT block.
// Optional auto CMD12 support is enabled with the SD_XFER_AUTO_CMD12_EN macro.
module sd_xfer_sequencer #(
  parameter int unsigned BC_W = 16,
  parameter int unsigned BS_W = 12
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start_cmd,
  input  logic [15:0]     transfer_mode,
  input  logic [BC_W-1:0] block_count,
  input  logic [BS_W-1:0] block_size,
  input  logic            stop_at_gap,
  input  logic            continue_req,
  input  logic            dma_block_done,
  input  logic            dat_block_done,
  input  logic            dat_crc_error,
  input  logic            auto_cmd12_done,
  output logic            dma_start,
  output logic            dat_start,
  output logic            dat_direction,
  output logic [BS_W-1:0] dat_block_size,
  output logic [BC_W-1:0] blocks_remaining,
  output logic            busy,
  output logic            transfer_complete,
  output logic            block_gap_event,
  output logic            data_error,
  output logic            auto_cmd12_req
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRun, StWaitBlk, StGap, StCmd12, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [BS_W-1:0] bsize_q, bsize_d;
  logic [BC_W-1:0] count_q, count_d;
  logic            infinite_q, infinite_d;
  logic            zero_cnt_q, zero_cnt_d;
  logic            dma_flag_q, dma_flag_d;
  logic            dat_flag_q, dat_flag_d;
  logic            gap_evt_q, gap_evt_d;
`ifdef SD_XFER_AUTO_CMD12_EN
  logic            acmd_q, acmd_d;
  logic            cmd12_req_q, cmd12_req_d;
`endif

  logic multi, bce, blk_done, last_blk;
  logic unused_inputs;

  assign multi    = transfer_mode[5];
  assign bce      = transfer_mode[1];
  assign blk_done = (dma_flag_q | dma_block_done) & (dat_flag_q | dat_block_done);
  assign last_blk = !infinite_q && (count_q <= BC_W'(1));

`ifdef SD_XFER_AUTO_CMD12_EN
  assign unused_inputs = ^{transfer_mode[15:6], transfer_mode[3], transfer_mode[0]};
`else
  assign unused_inputs = ^{transfer_mode[15:6], transfer_mode[3], transfer_mode[2],
                           transfer_mode[0], auto_cmd12_done};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      bsize_q     <= '0;
      count_q     <= '0;
      infinite_q  <= 1'b0;
      zero_cnt_q  <= 1'b0;
      dma_flag_q  <= 1'b0;
      dat_flag_q  <= 1'b0;
      gap_evt_q   <= 1'b0;
`ifdef SD_XFER_AUTO_CMD12_EN
      acmd_q      <= 1'b0;
      cmd12_req_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      bsize_q     <= bsize_d;
      count_q     <= count_d;
      infinite_q  <= infinite_d;
      zero_cnt_q  <= zero_cnt_d;
      dma_flag_q  <= dma_flag_d;
      dat_flag_q  <= dat_flag_d;
      gap_evt_q   <= gap_evt_d;
`ifdef SD_XFER_AUTO_CMD12_EN
      acmd_q      <= acmd_d;
      cmd12_req_q <= cmd12_req_d;
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    dir_d             = dir_q;
    bsize_d           = bsize_q;
    count_d           = count_q;
    infinite_d        = infinite_q;
    zero_cnt_d        = zero_cnt_q;
    dma_flag_d        = dma_flag_q;
    dat_flag_d        = dat_flag_q;
    gap_evt_d         = 1'b0;
`ifdef SD_XFER_AUTO_CMD12_EN
    acmd_d            = acmd_q;
    cmd12_req_d       = 1'b0;
`endif
    dma_start         = 1'b0;
    dat_start         = 1'b0;
    transfer_complete = 1'b0;
    data_error        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_cmd) begin
          state_d    = StLoad;
          dir_d      = transfer_mode[4];
          bsize_d    = block_size;
          count_d    = !multi ? BC_W'(1) : (bce ? block_count : '0);
          infinite_d = multi & !bce;
          zero_cnt_d = multi & bce & (block_count == '0);
`ifdef SD_XFER_AUTO_CMD12_EN
          acmd_d     = transfer_mode[2] & multi & bce;
`endif
        end
      end
      StLoad: begin
        if (bsize_q == '0)   state_d = StErr;
        else if (zero_cnt_q) state_d = StDone;
        else                 state_d = StRun;
      end
      StRun: begin
        dma_start  = 1'b1;
        dat_start  = 1'b1;
        dma_flag_d = 1'b0;
        dat_flag_d = 1'b0;
        state_d    = dat_crc_error ? StErr : StWaitBlk;
      end
      StWaitBlk: begin
        if (dat_crc_error) begin
          state_d = StErr;
        end else begin
          dma_flag_d = dma_flag_q | dma_block_done;
          dat_flag_d = dat_flag_q | dat_block_done;
          if (blk_done) begin
            if (!infinite_q && count_q != '0) count_d = count_q - BC_W'(1);
            // The last block always completes; a pending gap request is dropped.
            if (last_blk) begin
`ifdef SD_XFER_AUTO_CMD12_EN
              state_d     = acmd_q ? StCmd12 : StDone;
              cmd12_req_d = acmd_q;
`else
              state_d = StDone;
`endif
            end else if (stop_at_gap) begin
              state_d   = StGap;
              gap_evt_d = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end
      end
      StGap: begin
        if (dat_crc_error)     state_d = StErr;
        else if (continue_req) state_d = StRun;
      end
`ifdef SD_XFER_AUTO_CMD12_EN
      StCmd12: begin
        if (auto_cmd12_done) state_d = StDone;
      end
`endif
      StDone: begin
        transfer_complete = 1'b1;
        state_d           = StIdle;
      end
      StErr: begin
        data_error = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    block_gap_event  = gap_evt_q;
`ifdef SD_XFER_AUTO_CMD12_EN
    auto_cmd12_req   = cmd12_req_q;
`else
    auto_cmd12_req   = 1'b0;
`endif
    busy             = (state_q != StIdle);
    dat_direction    = dir_q;
    dat_block_size   = bsize_q;
    blocks_remaining = count_q;

    // Outputs are forced low for as long as reset is held.
    if (RESET) begin
      dma_start         = 1'b0;
      dat_start         = 1'b0;
      transfer_complete = 1'b0;
      data_error        = 1'b0;
      block_gap_event   = 1'b0;
      auto_cmd12_req    = 1'b0;
      busy              = 1'b0;
      dat_direction     = 1'b0;
      dat_block_size    = '0;
      blocks_remaining  = '0;
    end
  end

endmodule

// File: doc/sd_xfer_sequencer.md
Name: sd_xfer_sequencer

Overview:
Sequences one SD data transfer (single or multi-block) between the ADMA engine and the DAT line block through the shared buffer.
- Decodes the transfer mode, block count, block size and block-gap control register values.
- Issues per-block start pulses to DMA and DAT, and counts completed blocks.
- Handles stop-at-block-gap / continue and CRC error abort.
- Generates the status pulses written into the Normal Interrupt Status and Present State registers.
- Sits inside sd_host between the register bank and the dma / DAT instances.

Parameters:
BC_W, 16, width of block count and blocks_remaining
BS_W, 12, width of block size

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
start_cmd  in  1  one-cycle pulse: data command issued, begin transfer
transfer_mode  in  16  TMR value: bit1 block count enable (BCE), bit2 auto CMD12, bit4 direction (1=card->host read), bit5 multi-block
block_count  in  BC_W  BCR value
block_size  in  BS_W  BSR[11:0]
stop_at_gap  in  1  BGCR bit0
continue_req  in  1  BGCR bit1, one-cycle pulse
dma_block_done  in  1  pulse: DMA finished moving one block
dat_block_done  in  1  pulse: DAT finished one block on the card bus
dat_crc_error  in  1  pulse: DAT CRC / end-bit error
auto_cmd12_done  in  1  pulse: CMD block finished auto CMD12
dma_start  out  1  pulse: start DMA for one block
dat_start  out  1  pulse: start DAT for one block
dat_direction  out  1  latched transfer_mode bit4
dat_block_size  out  BS_W  latched block_size
blocks_remaining  out  BC_W  blocks still to transfer
busy  out  1  to PSR DAT inhibit; high from LOAD until return to IDLE
transfer_complete  out  1  pulse, NISR bit1
block_gap_event  out  1  pulse, NISR bit2
data_error  out  1  pulse, to EISR
auto_cmd12_req  out  1  pulse to CMD block

Behaviour:
- One clock (CLK); all state changes on the rising edge.
- RESET (synchronous, active-high) sends the FSM to IDLE on the next edge from any state, including mid-transfer. All outputs and counters are 0 while RESET is high.
- States: IDLE, LOAD, RUN, WAIT_BLK, GAP, CMD12, DONE, ERR.
- IDLE:
  - start_cmd=1 -> LOAD; latch direction, block size and count.
  - Count = 1 if bit5=0; block_count if bit5=1 and BCE=1; 0 (infinite) if bit5=1 and BCE=0.
  - start_cmd outside IDLE is ignored.
- LOAD (1 cycle):
  - block_size==0 -> ERR.
  - Else BCE=1, bit5=1, count==0 -> DONE, with no start pulses.
  - Else -> RUN.
- RUN (1 cycle): pulse dma_start and dat_start in the same cycle; clear both done flags; -> WAIT_BLK. Start pulses therefore appear 2 cycles after start_cmd.
- WAIT_BLK:
  - Set a sticky flag for each of dma_block_done and dat_block_done; either order or the same cycle is accepted.
  - When both flags are set, a block is complete. If count is finite, decrement blocks_remaining (no wrap below 0).
  - At block completion:
    - If finite count and it reaches 0: -> CMD12 when auto CMD12 applies, else DONE.
    - Else if stop_at_gap=1: -> GAP and pulse block_gap_event.
    - Else: -> RUN.
- GAP: continue_req=1 -> RUN. stop_at_gap is sampled only at block completion. A gap request on the last block is ignored; the transfer completes normally with no gap event.
- CMD12: pulse auto_cmd12_req on entry; wait for auto_cmd12_done -> DONE.
- DONE: pulse transfer_complete for 1 cycle -> IDLE.
- ERR: pulse data_error for 1 cycle -> IDLE; no transfer_complete.
- dat_crc_error in RUN, WAIT_BLK or GAP -> ERR. Error has priority over a block-done in the same cycle; blocks_remaining is then not decremented.
- busy deasserts on the edge the FSM enters IDLE.

Optional Feature:
SD_XFER_AUTO_CMD12_EN
- Defined: CMD12 state is used when transfer_mode bit2=1, bit5=1 and count is finite.
- Undefined: CMD12 state is never entered, auto_cmd12_req is tied 0, auto_cmd12_done is ignored, and the last block goes straight to DONE.

Test Plan:
1. Single block: TMR=0x0010, BSR=512, start_cmd -> one dma_start/dat_start at +2 cycles; after both dones, transfer_complete 1 cycle later; blocks_remaining 1->0.
2. Multi-block: TMR=0x0022, BCR=3, dones arrive in mixed order, including the same cycle -> exactly 3 start pairs, blocks_remaining 3,2,1,0, one transfer_complete.
3. Gap: BCR=4, stop_at_gap=1 after block 2 -> block_gap_event, no start until continue_req, then blocks 3 and 4 complete; stop_at_gap held through the last block gives no gap event.
4. Error: dat_crc_error in the same cycle as dat_block_done on block 1 of 2 -> data_error pulse, blocks_remaining stays 2, busy low next cycle, no transfer_complete.
5. Boundaries: BCE=1, multi, BCR=0 -> transfer_complete with no starts; block_size=0 -> data_error; RESET mid-WAIT_BLK -> all outputs 0, FSM in IDLE.
6. With SD_XFER_AUTO_CMD12_EN, TMR=0x0026, BCR=2 -> auto_cmd12_req after block 2; transfer_complete only 1 cycle after auto_cmd12_done. Without the macro -> no request.
